mux_case: RTL and testbench
===========================

# mux_case

Registered 4:1 multiplexer for narrow data words. Selects one of four equal-width inputs (a, b, c, d) by a 2-bit select and presents the result on a registered output one clock later. Used wherever a small, glitch-free, clock-aligned source selection is needed in the datapath. Also provides a registered copy of the applied select and a valid flag.

## Interface
- WIDTH, default 2: data width of a, b, c, d and o; legal range 1 to 64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- a  input  WIDTH  data source, select 2'b00.
- b  input  WIDTH  data source, select 2'b01.
- c  input  WIDTH  data source, select 2'b10.
- d  input  WIDTH  data source, select 2'b11.
- s  input  2  source select.
- o  output  WIDTH  registered selected data.
- s_q  output  2  select value captured with the current o.
- o_valid  output  1  high once o holds data captured after reset.

## Operation
- Combinational select:
  - s=00 selects a.
  - s=01 selects b.
  - s=10 selects c.
  - s=11 selects d.
- Any non-binary select value (X/Z in simulation) selects all-zeros through the default branch. It never propagates X to o.
- On every rising clk edge with rst_n high:
  - o takes the combinational selection.
  - s_q takes s.
  - o_valid is set to 1.
- No enable input; the output register is updated every cycle.
- Data passes bit-exact at width WIDTH. No arithmetic, no sign handling, no padding.
- Inputs a–d and s may change at any time. Only the values present at the sampling edge matter.

## Timing
- Latency: 1 clk cycle from s/data at the sampling edge to o.
- Throughput: one new selection per cycle.
- Reset (rst_n low, asynchronous): o=0, s_q=2'b00 and o_valid=0 immediately, independent of clk. All three hold while rst_n is low.
- Reset deassertion: the first rising clk edge with rst_n high loads o, s_q and o_valid=1. Deassertion must meet recovery/removal timing to clk.
- Reset asserted mid-operation: outputs clear within the same cycle. The sample in flight is discarded.
- Select changes between edges: no effect on o until the next edge, so o is glitch-free.
- Simultaneous change of s and the selected data before an edge: o reflects both new values at that edge.

## Test plan
- Reset check: hold rst_n=0 and toggle clk with a=00, b=01, c=11, d=00, s=01.
  - Required: o=00, s_q=00, o_valid=0 throughout.
- Full select sweep: release reset with a=00, b=01, c=11, d=00, then apply s=00, 01, 10, 11 for one edge each.
  - Required: o=00, 01, 11, 00 one cycle after each select.
  - Required: s_q tracks s with 1-cycle delay.
  - Required: o_valid=1 from the first edge after release.
- Data-follow check: set s=10 and change c from 11 to 10 between edges.
  - Required: o=11 until the next edge, then 10.
  - Required: changes on a, b and d have no effect.
- Undefined select: drive s=2'bxx for one edge with all inputs nonzero.
  - Required: o=00, with no X on o.
- Async reset mid-stream: with o=11, pulse rst_n low between edges.
  - Required: o=00 and o_valid=0 before the next edge.
  - Required: after release, normal selection resumes on the first edge.
- Width parameter: set WIDTH=8 with a=8'hA5, b=8'h5A, c=8'hFF, d=8'h01 and sweep s.
  - Required: o=A5, 5A, FF, 01 in order.

Source files
------------

// File: rtl/mux_case.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_case                                                     |
// | Description : Registered 4:1 multiplexer. One of four equal-width sources  |
// |               (a, b, c, d) is chosen by a 2-bit select. The choice is      |
// |               registered, so o is clock-aligned and glitch-free. A         |
// |               registered copy of the select and a valid flag go with it.   |
// | Ports       : clk     - rising-edge clock                                  |
// |               rst_n   - asynchronous, active-low reset                     |
// |               a..d    - data sources for select 00..11 (WIDTH bits)        |
// |               s       - 2-bit source select                                |
// |               o       - registered selected data (WIDTH bits)              |
// |               s_q     - select value that produced the current o           |
// |               o_valid - high once o holds data captured after reset        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_case #(
  parameter int WIDTH = 2  // legal range 1..64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] o,
  output logic [1:0]       s_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_o;
  logic [1:0]       r_s_q;
  logic             r_valid;

  // The default branch catches a select that is not a clean binary value
  // (X/Z in simulation). It forces zeros so that an unknown select never
  // leaks X into the output register.
  always_comb begin
    w_sel = '0;
    case (s)
      2'b00:   w_sel = a;
      2'b01:   w_sel = b;
      2'b10:   w_sel = c;
      2'b11:   w_sel = d;
      default: w_sel = '0;
    endcase
  end

  // No enable: the output register reloads every cycle. Reset is
  // asynchronous, so a sample in flight is dropped when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o     <= '0;
      r_s_q   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_o     <= w_sel;
      r_s_q   <= s;
      r_valid <= 1'b1;
    end
  end

  assign o       = r_o;
  assign s_q     = r_s_q;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_case.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_case                                                  |
// | Description : Self-checking bench for mux_case. Two instances (WIDTH=2     |
// |               and WIDTH=8) share clock, reset and select. Expected values  |
// |               come from a table lookup of the four sources by select.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mux_case;

  logic       clk;
  logic       rst_n;
  logic [1:0] s;

  logic [1:0] a2, b2, c2, d2, o2;
  logic [1:0] s_q2;
  logic       v2;

  logic [7:0] a8, b8, c8, d8, o8;
  logic [1:0] s_q8;
  logic       v8;

  int n_total;
  int n_pass;

  mux_case #(.WIDTH(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a2),
    .b       (b2),
    .c       (c2),
    .d       (d2),
    .s       (s),
    .o       (o2),
    .s_q     (s_q2),
    .o_valid (v2)
  );

  mux_case #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a8),
    .b       (b8),
    .c       (c8),
    .d       (d8),
    .s       (s),
    .o       (o8),
    .s_q     (s_q8),
    .o_valid (v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: the output register holds the source indexed by the select
  // value seen at the edge, or all-zeros if that select is not binary.
  function automatic logic [7:0] ref8(input logic [1:0] sel);
    logic [7:0] src [4];
    src[0] = a8; src[1] = b8; src[2] = c8; src[3] = d8;
    if ($isunknown(sel)) return 8'h00;
    return src[sel];
  endfunction

  function automatic logic [1:0] ref2(input logic [1:0] sel);
    logic [1:0] src [4];
    src[0] = a2; src[1] = b2; src[2] = c2; src[3] = d2;
    if ($isunknown(sel)) return 2'b00;
    return src[sel];
  endfunction

  // Apply the currently driven inputs for one edge, then check all outputs.
  task automatic tick(input string tag);
    logic [1:0] e2, es;
    logic [7:0] e8;
    e2 = ref2(s);
    e8 = ref8(s);
    es = s;
    @(posedge clk);
    #1;
    chk({tag, ".o2"}, 64'(o2), 64'(e2));
    chk({tag, ".o8"}, 64'(o8), 64'(e8));
    chk({tag, ".s_q"}, 64'(s_q2), 64'(es));
    chk({tag, ".s_q8"}, 64'(s_q8), 64'(es));
    chk({tag, ".valid"}, 64'({v2, v8}), 64'(2'b11));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".o2"}, 64'(o2), 64'd0);
    chk({tag, ".o8"}, 64'(o8), 64'd0);
    chk({tag, ".s_q"}, 64'({s_q2, s_q8}), 64'd0);
    chk({tag, ".valid"}, 64'({v2, v8}), 64'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Reset held low while the clock runs.
    rst_n = 1'b0;
    a2 = 2'b00; b2 = 2'b01; c2 = 2'b11; d2 = 2'b00;
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hFF; d8 = 8'h01;
    s  = 2'b01;
    #2;
    chk_reset_state("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_state("rst_hold");
    end

    // Release reset between edges, then sweep the select.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      tick("sweep");
    end

    // Data follow: c changes mid-cycle; o holds until the next edge.
    s  = 2'b10;
    c2 = 2'b11;
    tick("follow0");
    c2 = 2'b10;
    c8 = 8'h3C;
    a2 = 2'b01; b2 = 2'b10; d2 = 2'b11;
    a8 = 8'h11; b8 = 8'h22; d8 = 8'h44;
    #2;
    chk("follow_hold.o2", 64'(o2), 64'(2'b11));
    chk("follow_hold.o8", 64'(o8), 64'(8'hFF));
    tick("follow1");

    // Unknown select: forces zeros where the simulator models X.
    a2 = 2'b01; b2 = 2'b10; c2 = 2'b11; d2 = 2'b01;
    s  = 2'bxx;
    begin
      logic [1:0] e2;
      logic [7:0] e8;
      e2 = ref2(s);
      e8 = ref8(s);
      @(posedge clk);
      #1;
      chk("xsel.o2", 64'(o2), 64'(e2));
      chk("xsel.o8", 64'(o8), 64'(e8));
      chk("xsel.known", 64'($isunknown({o2, o8})), 64'd0);
    end

    // Asynchronous reset mid-cycle with o = 11.
    s = 2'b10;
    tick("pre_rst");
    chk("pre_rst.o_is_11", 64'(o2), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    #1 rst_n = 1'b1;
    s = 2'b01;
    tick("post_rst");

    // Randomized traffic, with an occasional asynchronous reset pulse.
    for (int i = 0; i < 300; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom); c2 = 2'($urandom); d2 = 2'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      s  = 2'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("rand_rst");
        #1 rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
